// File: rtl/cbadd_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/sub built around one 4-bit carry-bypass slice.
// Optional signed overflow output enabled by defining CBADD_SEQ_OVF_EN.
module cbadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s = p ^ c[3:0];
    // all four bits propagate: carry-in skips the ripple chain
    co = (&p) ? ci : c[4];
  end

endmodule

module cbadd_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CBADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [3:0]      sl_a;
  logic [3:0]      sl_b;
  logic [3:0]      sl_s;
  logic            sl_co;
  logic            last;
  logic            accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (idx_q == IW'(NIB - 1));
  assign sl_a      = opa_q[idx_q*4 +: 4];
  assign sl_b      = opb_q[idx_q*4 +: 4];

  cbadder u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      opa_q   <= a;
      opb_q   <= sub ? ~b : b;
      carry_q <= sub | cin;
      idx_q   <= '0;
    end else if (state == RUN) begin
      sum[idx_q*4 +: 4] <= sl_s;
      carry_q           <= sl_co;
      idx_q             <= idx_q + IW'(1);
      if (last) begin
        cout <= sl_co;
      end
    end
  end

`ifdef CBADD_SEQ_OVF_EN
  // operands of equal sign whose result sign flips
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= (opa_q[WIDTH-1] ~^ opb_q[WIDTH-1])
           & (opa_q[WIDTH-1] ^ sl_s[3]);
    end
  end
`endif

endmodule

// File: tb/tb_cbadd_seq_ctrl.sv
// Self-checking bench for cbadd_seq_ctrl at WIDTH=16.
// Table vectors, corner sequences and a randomized arithmetic model.
module tb_cbadd_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CBADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int nvec = 0;
  int nerr = 0;

  cbadd_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CBADD_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on unsigned and signed views
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mcin, input logic msub,
                       output logic [W-1:0] s, output logic c,
                       output logic o);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub + int'(mcin);
      sr = sa + sb + int'(mcin);
      c  = (ur > 65535);
    end
    s = ur[W-1:0];
    o = (sr > 32767) || (sr < -32768);
  endtask

  // accept one op, measure latency, check result, then drain
  task automatic run_op(input string nm, input vec_t v, input int hold);
    int lat;
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    sub      = v.sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    sub      = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'd4);
    chk({nm, ".sum"}, 32'(sum), 32'(v.esum));
    chk({nm, ".cout"}, 32'(cout), 32'(v.ecout));
`ifdef CBADD_SEQ_OVF_EN
    chk({nm, ".ovf"}, 32'(ovf), 32'(v.eovf));
`endif
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, ".drain_ov"}, 32'(out_valid), 32'd0);
    chk({nm, ".drain_ir"}, 32'(in_ready), 32'd1);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;
    logic [W-1:0] hs;
    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i], 0);
    end

    // result must stay frozen while the consumer stalls
    run_op("hold_pre", tbl[0], 0);
    a = 16'h00AA; b = 16'h0055; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold.ov0", 32'(out_valid), 32'd1);
    hs = sum;
    chk("hold.sum0", 32'(sum), 32'h00FF);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a        = W'($urandom);
      @(posedge clk);
      #1;
      chk("hold.sum", 32'(sum), 32'(hs));
      chk("hold.ov", 32'(out_valid), 32'd1);
      chk("hold.ir", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold.rel_ov", 32'(out_valid), 32'd0);
    chk("hold.rel_ir", 32'(in_ready), 32'd1);

    // abort mid-run with reset
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.ov", 32'(out_valid), 32'd0);
    chk("abort.sum", 32'(sum), 32'd0);
    chk("abort.ir", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort.no_ov", 32'(out_valid), 32'd0);
    end
    run_op("abort.next", tbl[5], 0);

    for (int i = 0; i < 40; i++) begin
      v.a   = W'($urandom);
      v.b   = W'($urandom);
      v.cin = 1'($urandom);
      v.sub = 1'($urandom);
      if (i == 0) begin v.a = 16'hFFFF; v.b = 16'hFFFF; v.cin = 1'b1; v.sub = 1'b0; end
      if (i == 1) begin v.a = 16'h0000; v.b = 16'h0000; v.sub = 1'b1; end
      model(v.a, v.b, v.cin, v.sub, v.esum, v.ecout, v.eovf);
      run_op($sformatf("rnd%0d", i), v, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
